// File: rtl/pcpu_run_ctrl_if.sv
// Program-load port between a host and the pcpu run controller.
// A beat transfers on any rising clock edge where ld_valid and ld_ready are both high; the master
// holds ld_addr/ld_data/ld_last stable while ld_valid waits, and ld_ready never depends on ld_valid.
interface pcpu_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    modport master (output ld_valid, ld_addr, ld_data, ld_last, input ld_ready);
    modport slave  (input ld_valid, ld_addr, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/pcpu_run_ctrl.sv
// Run controller for the pcpu: loads imem, pulses enable/start, watches for HALT, drains the
// pipeline and reports done, timeout, halt PC and run-cycle count.
module pcpu_run_ctrl #(
    parameter int          ADDR_W     = 8,
    parameter int          DATA_W     = 16,
    parameter int          CNT_W      = 16,
    parameter int          MAX_CYCLES = 1000,
    parameter int          DRAIN_CYC  = 4,
    parameter logic [4:0]  HALT_OP    = 5'b00001
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    pcpu_run_ctrl_if.slave    ld,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_enable,
    output logic              cpu_start,
    input  logic [ADDR_W-1:0] cpu_i_addr,
    input  logic [DATA_W-1:0] cpu_i_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W-1:0] halt_pc,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARM   = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DATA_W-1:0] OP_MASK  = {5'h1f, {(DATA_W-5){1'b0}}};
    localparam logic [DATA_W-1:0] OP_MATCH = {HALT_OP, {(DATA_W-5){1'b0}}};

    state_t             state;
    logic [DRN_W-1:0]   drain_cnt;
    logic               accept;
    logic               halt_hit;
    logic               limit_hit;

    assign ld.ld_ready = (state == S_LOAD);
    assign accept      = ld.ld_valid & ld.ld_ready;
    // Opcode lives in the top five bits of the fetched word.
    assign halt_hit    = ((cpu_i_data & OP_MASK) == OP_MATCH);
    assign limit_hit   = ((cycle_count + 1'b1) == CNT_W'(MAX_CYCLES));
    assign dbg_state   = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            cpu_enable  <= 1'b0;
            cpu_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            halt_pc     <= '0;
            cycle_count <= '0;
        end else begin
            im_we     <= 1'b0;
            cpu_start <= 1'b0;
            if (abort) begin
                // Results (counters, halt_pc, timeout) survive an abort for post-mortem.
                state      <= S_IDLE;
                cpu_enable <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (go) begin
                            state       <= S_LOAD;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            timeout     <= 1'b0;
                            halt_pc     <= '0;
                            cycle_count <= '0;
                            cpu_enable  <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        if (accept) begin
                            im_we    <= 1'b1;
                            im_addr  <= ld.ld_addr;
                            im_wdata <= ld.ld_data;
                            if (ld.ld_last) begin
                                state      <= S_ARM;
                                cpu_enable <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        state     <= S_START;
                        cpu_start <= 1'b1;
                    end
                    S_START: begin
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        cycle_count <= cycle_count + 1'b1;
                        // HALT takes precedence over the cycle limit in the same cycle.
                        if (halt_hit) begin
                            halt_pc   <= cpu_i_addr;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end else if (limit_hit) begin
                            timeout    <= 1'b1;
                            cpu_enable <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_DONE;
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == DRN_W'(DRAIN_CYC - 1)) begin
                            cpu_enable <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcpu_run_ctrl.sv
// Directed bench for pcpu_run_ctrl: load, HALT/drain, timeout, HALT-at-limit and abort scenarios.
module tb_pcpu_run_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go    = 1'b0;
    logic        abort = 1'b0;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_enable;
    logic        cpu_start;
    logic [7:0]  cpu_i_addr = 8'h00;
    logic [15:0] cpu_i_data = 16'h0000;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  halt_pc;
    logic [15:0] cycle_count;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  beat_a [3] = '{8'h00, 8'h01, 8'h02};
    logic [15:0] beat_d [3] = '{16'h4319, 16'h0000, 16'h1808};

    pcpu_run_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ld ();

    pcpu_run_ctrl #(
        .ADDR_W(8), .DATA_W(16), .CNT_W(16), .MAX_CYCLES(16), .DRAIN_CYC(4), .HALT_OP(5'b00001)
    ) dut (
        .clock(clock), .reset(reset), .go(go), .abort(abort), .ld(ld.slave),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .cpu_i_addr(cpu_i_addr), .cpu_i_data(cpu_i_data),
        .busy(busy), .done(done), .timeout(timeout), .halt_pc(halt_pc),
        .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic run_load();
        cpu_i_data = 16'h0000;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld.ld_valid = 1'b1;
            ld.ld_addr  = beat_a[i];
            ld.ld_data  = beat_d[i];
            ld.ld_last  = (i == 2);
            tick();
        end
        ld.ld_valid = 1'b0;
        ld.ld_last  = 1'b0;
        tick();
        tick();
    endtask

    // scenarios
    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({im_we, cpu_enable, cpu_start, busy, done, timeout, ld.ld_ready} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {im_we, cpu_enable, cpu_start, busy, done, timeout, ld.ld_ready});
        end
        n_cmp++;
        if ({halt_pc, cycle_count, im_addr, im_wdata} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_values: got %h want 0", {halt_pc, cycle_count, im_addr, im_wdata});
        end
        reset = 1'b1;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        ld.ld_valid = 1'b1;
        ld.ld_addr  = 8'h05;
        ld.ld_data  = 16'habcd;
        ld.ld_last  = 1'b0;
        tick();
        n_cmp++;
        if ({im_we, ld.ld_ready, busy} !== 3'b111) begin
            n_err++;
            $display("FAIL midload_pre_reset: got %b want 111", {im_we, ld.ld_ready, busy});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({im_we, ld.ld_ready, busy, cpu_enable, im_addr, im_wdata} !== 28'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h want 0",
                     {im_we, ld.ld_ready, busy, cpu_enable, im_addr, im_wdata});
        end
        tick();
        reset = 1'b1;
        ld.ld_valid = 1'b0;
        tick();
        n_cmp++;
        if ({dbg_state, ld.ld_ready} !== {ST_IDLE, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b want %b", {dbg_state, ld.ld_ready}, {ST_IDLE, 1'b0});
        end
    endtask

    task automatic test_load();
        // HALT word visible throughout LOAD/ARM/START must not end anything
        cpu_i_data = 16'h0800;
        cpu_i_addr = 8'h77;
        go = 1'b1;
        tick();
        go = 1'b0;
        n_cmp++;
        if ({dbg_state, ld.ld_ready, busy, cycle_count} !== {ST_LOAD, 2'b11, 16'h0}) begin
            n_err++;
            $display("FAIL load_entry: got %h want %h",
                     {dbg_state, ld.ld_ready, busy, cycle_count}, {ST_LOAD, 2'b11, 16'h0});
        end
        for (int i = 0; i < 3; i++) begin
            ld.ld_valid = 1'b1;
            ld.ld_addr  = beat_a[i];
            ld.ld_data  = beat_d[i];
            ld.ld_last  = (i == 2);
            tick();
            n_cmp++;
            if ({im_we, im_addr, im_wdata, cpu_enable, cpu_start} !== {1'b1, beat_a[i], beat_d[i], (i == 2), 1'b0}) begin
                n_err++;
                $display("FAIL load_beat%0d: got %h want %h", i,
                         {im_we, im_addr, im_wdata, cpu_enable, cpu_start},
                         {1'b1, beat_a[i], beat_d[i], (i == 2), 1'b0});
            end
        end
        ld.ld_valid = 1'b0;
        ld.ld_last  = 1'b0;
        n_cmp++;
        if ({dbg_state, ld.ld_ready} !== {ST_ARM, 1'b0}) begin
            n_err++;
            $display("FAIL arm_state: got %b want %b", {dbg_state, ld.ld_ready}, {ST_ARM, 1'b0});
        end
        tick();
        n_cmp++;
        if ({dbg_state, cpu_enable, cpu_start, im_we} !== {ST_START, 3'b110}) begin
            n_err++;
            $display("FAIL start_pulse: got %b want %b",
                     {dbg_state, cpu_enable, cpu_start, im_we}, {ST_START, 3'b110});
        end
        tick();
        n_cmp++;
        if ({dbg_state, cpu_enable, cpu_start, busy, cycle_count} !== {ST_RUN, 3'b101, 16'h0}) begin
            n_err++;
            $display("FAIL run_entry: got %h want %h",
                     {dbg_state, cpu_enable, cpu_start, busy, cycle_count}, {ST_RUN, 3'b101, 16'h0});
        end
    endtask

    task automatic test_halt();
        for (int k = 1; k <= 10; k++) begin
            cpu_i_addr = 8'(k);
            cpu_i_data = (k == 10) ? 16'h0800 : 16'h2000 + 16'(k);
            tick();
            if (k == 9) begin
                n_cmp++;
                if ({dbg_state, cycle_count} !== {ST_RUN, 16'd9}) begin
                    n_err++;
                    $display("FAIL halt_pre_run9: got %h want %h", {dbg_state, cycle_count}, {ST_RUN, 16'd9});
                end
            end
        end
        cpu_i_addr = 8'h55;
        n_cmp++;
        if ({dbg_state, cycle_count, halt_pc, cpu_enable, done} !== {ST_DRAIN, 16'd10, 8'h0a, 2'b10}) begin
            n_err++;
            $display("FAIL halt_detect: got %h want %h",
                     {dbg_state, cycle_count, halt_pc, cpu_enable, done}, {ST_DRAIN, 16'd10, 8'h0a, 2'b10});
        end
        for (int d = 1; d <= 3; d++) begin
            tick();
            n_cmp++;
            if ({dbg_state, cpu_enable, done} !== {ST_DRAIN, 2'b10}) begin
                n_err++;
                $display("FAIL drain_cycle%0d: got %b want %b", d, {dbg_state, cpu_enable, done}, {ST_DRAIN, 2'b10});
            end
        end
        tick();
        cpu_i_data = 16'h0000;
        n_cmp++;
        if ({dbg_state, done, timeout, cpu_enable, busy, cycle_count, halt_pc} !==
            {ST_DONE, 4'b1000, 16'd10, 8'h0a}) begin
            n_err++;
            $display("FAIL halt_done: got %h want %h",
                     {dbg_state, done, timeout, cpu_enable, busy, cycle_count, halt_pc},
                     {ST_DONE, 4'b1000, 16'd10, 8'h0a});
        end
    endtask

    task automatic test_timeout();
        run_load();
        for (int k = 1; k <= 16; k++) begin
            cpu_i_data = 16'h1000;
            cpu_i_addr = 8'(k);
            tick();
            if (k == 15) begin
                n_cmp++;
                if ({dbg_state, cpu_enable, done, cycle_count} !== {ST_RUN, 2'b10, 16'd15}) begin
                    n_err++;
                    $display("FAIL timeout_run15: got %h want %h",
                             {dbg_state, cpu_enable, done, cycle_count}, {ST_RUN, 2'b10, 16'd15});
                end
            end
        end
        n_cmp++;
        if ({dbg_state, done, timeout, cpu_enable, busy, cycle_count} !== {ST_DONE, 4'b1100, 16'd16}) begin
            n_err++;
            $display("FAIL timeout_done: got %h want %h",
                     {dbg_state, done, timeout, cpu_enable, busy, cycle_count}, {ST_DONE, 4'b1100, 16'd16});
        end
        cpu_i_data = 16'h0800;
        tick();
        tick();
        n_cmp++;
        if ({dbg_state, done, timeout, cycle_count, halt_pc} !== {ST_DONE, 2'b11, 16'd16, 8'h00}) begin
            n_err++;
            $display("FAIL timeout_hold: got %h want %h",
                     {dbg_state, done, timeout, cycle_count, halt_pc}, {ST_DONE, 2'b11, 16'd16, 8'h00});
        end
    endtask

    task automatic test_limit_halt();
        run_load();
        n_cmp++;
        if ({timeout, done, cycle_count} !== {2'b00, 16'd0}) begin
            n_err++;
            $display("FAIL rerun_clear: got %h want %h", {timeout, done, cycle_count}, {2'b00, 16'd0});
        end
        for (int k = 1; k <= 16; k++) begin
            cpu_i_data = (k == 16) ? 16'h0800 : 16'h0000;
            cpu_i_addr = 8'h30 + 8'(k);
            tick();
        end
        cpu_i_data = 16'h0000;
        n_cmp++;
        if ({dbg_state, timeout, cpu_enable, cycle_count, halt_pc} !== {ST_DRAIN, 2'b01, 16'd16, 8'h40}) begin
            n_err++;
            $display("FAIL limit_halt_drain: got %h want %h",
                     {dbg_state, timeout, cpu_enable, cycle_count, halt_pc}, {ST_DRAIN, 2'b01, 16'd16, 8'h40});
        end
        repeat (4) tick();
        n_cmp++;
        if ({dbg_state, done, timeout, cpu_enable, cycle_count} !== {ST_DONE, 3'b100, 16'd16}) begin
            n_err++;
            $display("FAIL limit_halt_done: got %h want %h",
                     {dbg_state, done, timeout, cpu_enable, cycle_count}, {ST_DONE, 3'b100, 16'd16});
        end
    endtask

    task automatic test_abort();
        go = 1'b1;
        tick();
        n_cmp++;
        if ({dbg_state, ld.ld_ready, done, timeout, cycle_count, halt_pc} !== {ST_LOAD, 3'b100, 16'd0, 8'h00}) begin
            n_err++;
            $display("FAIL done_restart: got %h want %h",
                     {dbg_state, ld.ld_ready, done, timeout, cycle_count, halt_pc}, {ST_LOAD, 3'b100, 16'd0, 8'h00});
        end
        for (int i = 0; i < 3; i++) begin
            ld.ld_valid = 1'b1;
            ld.ld_addr  = beat_a[i];
            ld.ld_data  = beat_d[i];
            ld.ld_last  = (i == 2);
            tick();
            if (i == 0) begin
                n_cmp++;
                if ({dbg_state, im_we} !== {ST_LOAD, 1'b1}) begin
                    n_err++;
                    $display("FAIL go_in_load_ignored: got %b want %b", {dbg_state, im_we}, {ST_LOAD, 1'b1});
                end
            end
        end
        go = 1'b0;
        ld.ld_valid = 1'b0;
        ld.ld_last  = 1'b0;
        tick();
        tick();
        for (int k = 1; k <= 4; k++) begin
            cpu_i_data = 16'h0000;
            tick();
        end
        n_cmp++;
        if ({dbg_state, cycle_count} !== {ST_RUN, 16'd4}) begin
            n_err++;
            $display("FAIL abort_pre: got %h want %h", {dbg_state, cycle_count}, {ST_RUN, 16'd4});
        end
        abort = 1'b1;
        go    = 1'b1;
        tick();
        abort = 1'b0;
        go    = 1'b0;
        n_cmp++;
        if ({dbg_state, cpu_enable, cpu_start, im_we, done, busy, cycle_count} !== {ST_IDLE, 5'b00000, 16'd4}) begin
            n_err++;
            $display("FAIL abort_idle: got %h want %h",
                     {dbg_state, cpu_enable, cpu_start, im_we, done, busy, cycle_count}, {ST_IDLE, 5'b00000, 16'd4});
        end
    endtask

    initial begin
        ld.ld_valid = 1'b0;
        ld.ld_addr  = 8'h00;
        ld.ld_data  = 16'h0000;
        ld.ld_last  = 1'b0;
        test_reset();
        test_load();
        test_halt();
        test_timeout();
        test_limit_halt();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
